// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window walker: mode and state
// encodings, a constant clog2 helper and the parameter legality check.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_t;

  // Ceiling log2 usable in constant expressions; pool_clog2(1) = 0.
  function automatic int pool_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Counter width: never narrower than one bit.
  function automatic int pool_width(input int count);
    int w;
    w = pool_clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

  // K must be a power of two and the stride must tile both axes exactly.
  function automatic bit pool_params_ok(input int ih, input int iw,
                                        input int k, input int s);
    return (k > 0) && ((k & (k - 1)) == 0) && (s > 0) &&
           (ih >= k) && (iw >= k) &&
           (((ih - k) % s) == 0) && (((iw - k) % s) == 0);
  endfunction

endpackage

// File: rtl/pool_win_reduce.sv
// Combinational reduction of one KxK window to a single signed value,
// either signed maximum or floor average.
// Build option: POOL_RELU_EN clamps negative results to zero.
module pool_win_reduce
  import pool_pkg::*;
#(
  parameter int DW = 8,
  parameter int K  = 2
) (
  input  logic [K*K*DW-1:0] win,
  input  logic              mode,
  output logic [DW-1:0]     result
);

  localparam int KK = K * K;
  localparam int SH = pool_clog2(KK);
  localparam int SW = DW + SH;

  logic signed [DW-1:0] elem;
  logic signed [DW-1:0] max_v;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] avg_v;
  logic signed [DW-1:0] reduced;

  // Scan every element once, tracking the running max and the wide sum.
  always_comb begin
    elem  = '0;
    max_v = signed'(win[DW-1:0]);
    sum   = '0;
    for (int e = 0; e < KK; e++) begin
      elem = signed'(win[e*DW +: DW]);
      if (elem > max_v) max_v = elem;
      sum = sum + SW'(elem);
    end
    avg_v = sum >>> SH;
    if (mode == POOL_AVG) reduced = avg_v[DW-1:0];
    else                  reduced = max_v;
  end

  // Optional rectifier on the reduced value.
  always_comb begin
`ifdef POOL_RELU_EN
    if (reduced[DW-1]) result = '0;
    else               result = reduced;
`else
    result = reduced;
`endif
  end

endmodule

// File: rtl/pool_window_walker.sv
// 2-D pooling engine: captures one feature map, walks every KxK window
// at stride S in raster order and streams the reduced values out over a
// valid/ready handshake. Build option POOL_RELU_EN (see pool_win_reduce)
// clamps negative results to zero without changing timing.
module pool_window_walker
  import pool_pkg::*;
#(
  parameter  int DW = 8,
  parameter  int IH = 6,
  parameter  int IW = 6,
  parameter  int K  = 2,
  parameter  int S  = 2,
  localparam int OH = (IH - K) / S + 1,
  localparam int OW = (IW - K) / S + 1,
  localparam int RW = pool_width(OH),
  localparam int CW = pool_width(OW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IH*IW*DW-1:0] fmap_lin,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                out_last,
  output logic                busy
);

  if (!pool_params_ok(IH, IW, K, S)) begin : g_param_check
    $error("pool_window_walker: K must be a power of 2 and S must tile IH/IW");
  end

  pool_state_t          state_q, state_d;
  logic [IH*IW*DW-1:0]  map_q;
  logic                 mode_q;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 last_d;
  logic                 accept, xfer, load;
  logic [K*K*DW-1:0]    win_flat;
  logic [DW-1:0]        win_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake decode; a new result loads on the first RUN
  // cycle and on every non-final transfer.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    xfer     = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        xfer = out_valid && out_ready;
        load = !out_valid || (xfer && !out_last);
        if (xfer && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster-order advance of the window counters on each transfer.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (xfer && !out_last) begin
      if (col_q == CW'(OW - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    last_d = (row_d == RW'(OH - 1)) && (col_d == CW'(OW - 1));
  end

  // Window counters, cleared when a map is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      row_q <= '0;
      col_q <= '0;
    end else if (xfer) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Map and mode capture at accept; held for the whole walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q  <= '0;
      mode_q <= POOL_MAX;
    end else if (accept) begin
      map_q  <= fmap_lin;
      mode_q <= mode;
    end
  end

  // Gather from the next-state counters so the output register can load
  // the following window on the same edge as a transfer.
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_flat[(i*K + j)*DW +: DW] =
          map_q[((int'(row_d)*S + i)*IW + int'(col_d)*S + j)*DW +: DW];
      end
    end
  end

  pool_win_reduce #(
    .DW (DW),
    .K  (K)
  ) u_reduce (
    .win    (win_flat),
    .mode   (mode_q),
    .result (win_result)
  );

  // Output register: holds steady under backpressure, drops valid after
  // the last window is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (xfer && out_last) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_data  <= win_result;
        out_row   <= row_d;
        out_col   <= col_d;
        out_last  <= last_d;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_walker.sv
// Self-checking bench for pool_window_walker with a queue scoreboard.
module tb_pool_window_walker;

  localparam int DW   = 8;
  localparam int IH   = 6;
  localparam int IW   = 6;
  localparam int K    = 2;
  localparam int S    = 2;
  localparam int OH   = 3;
  localparam int OW   = 3;
  localparam int NWIN = OH * OW;
  localparam int MAPW = IH * IW * DW;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [MAPW-1:0] fmap_lin;
  logic            mode;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_last;
  logic            busy;

  exp_t       sb[$];
  int         tests_run;
  int         tests_failed;
  logic [7:0] obs_data [NWIN];
  logic [7:0] max_ref  [NWIN] = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};
  logic [7:0] avg_ref  [NWIN] = '{8'd3, 8'd5, 8'd7, 8'd15, 8'd17, 8'd19, 8'd27, 8'd29, 8'd31};
  logic [MAPW-1:0] idx_map;

  pool_window_walker #(
    .DW (DW), .IH (IH), .IW (IW), .K (K), .S (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmap_lin  (fmap_lin),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference window result using plain integer arithmetic.
  function automatic exp_t model_win(input logic [MAPW-1:0] m, input logic md,
                                     input int r, input int c);
    exp_t e;
    int   v, mx, sum, q;
    mx  = -100000;
    sum = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        v = $signed(m[((r*S + i)*IW + c*S + j)*DW +: DW]);
        sum += v;
        if (v > mx) mx = v;
      end
    end
    if (md) begin
      q = sum / (K*K);
      if ((sum % (K*K)) != 0 && sum < 0) q = q - 1;
    end else begin
      q = mx;
    end
`ifdef POOL_RELU_EN
    if (q < 0) q = 0;
`endif
    e.data = q[7:0];
    e.row  = r[1:0];
    e.col  = c[1:0];
    e.last = (r == OH-1) && (c == OW-1);
    return e;
  endfunction

  task automatic push_map(input logic [MAPW-1:0] m, input logic md);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        sb.push_back(model_win(m, md, r, c));
  endtask

  function automatic logic [MAPW-1:0] random_map();
    logic [MAPW-1:0] m;
    for (int e = 0; e < IH*IW; e++) m[e*DW +: DW] = DW'($urandom_range(0, 255));
    return m;
  endfunction

  // Offer a map starting at a negedge; returns at the negedge after accept.
  task automatic apply_map(input logic [MAPW-1:0] m, input logic md);
    int waitc;
    waitc    = 0;
    fmap_lin = m;
    mode     = md;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (in_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    push_map(m, md);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b0;
    fmap_lin  = '0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    tests_run++;
    if (busy !== 1'b0 || out_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy_last: got %b/%b required 0/0", busy, out_last); end
    tests_run++;
    if (out_data !== 8'h00 || out_row !== 2'd0 || out_col !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h (%0d,%0d) required 00 (0,0)", out_data, out_row, out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Walk a full map, optionally stalling 3 cycles on window (1,1).
  task automatic test_stream(input string name, input logic [MAPW-1:0] m,
                             input logic md, input bit stall);
    int   cyc, stalls, k;
    exp_t e;
    apply_map(m, md);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: valid/busy %b/%b required 0/1", name, out_valid, busy);
    end
    cyc = 0; stalls = 0; k = 0;
    out_ready = 1'b1;
    while (sb.size() > 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL %s_valid: out_valid=%b required 1 (cycle %0d)", name, out_valid, cyc);
      end else begin
        e = sb[0];
        if (out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
          tests_failed++;
          $display("[TB] FAIL %s_result: got %h (%0d,%0d) last=%b required %h (%0d,%0d) last=%b",
                   name, out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
        if (k < NWIN) obs_data[k] = out_data;
        if (stall && e.row == 2'd1 && e.col == 2'd1 && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
          void'(sb.pop_front());
          k++;
        end
      end
    end
    out_ready = 1'b1;
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: %0d results outstanding required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_end: valid/in_ready/busy %b/%b/%b required 0/1/0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_max_mode();
    test_stream("max", idx_map, 1'b0, 1'b0);
    for (int k = 0; k < NWIN; k++) begin
      tests_run++;
      if (obs_data[k] !== max_ref[k]) begin
        tests_failed++;
        $display("[TB] FAIL max_ref[%0d]: got %0d required %0d", k, obs_data[k], max_ref[k]);
      end
    end
  endtask

  task automatic test_avg_mode();
    test_stream("avg", idx_map, 1'b1, 1'b0);
    for (int k = 0; k < NWIN; k++) begin
      tests_run++;
      if (obs_data[k] !== avg_ref[k]) begin
        tests_failed++;
        $display("[TB] FAIL avg_ref[%0d]: got %0d required %0d", k, obs_data[k], avg_ref[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    test_stream("stall", idx_map, 1'b0, 1'b1);
    tests_run++;
    if (obs_data[4] !== 8'd21 || obs_data[5] !== 8'd23) begin
      tests_failed++;
      $display("[TB] FAIL stall_values: got %0d,%0d required 21,23", obs_data[4], obs_data[5]);
    end
  endtask

  task automatic test_signed();
    logic [MAPW-1:0] m;
    logic [7:0]      exp_avg, exp_max;
    m = random_map();
    m[0*DW +: DW] = 8'hFF; m[1*DW +: DW] = 8'hFF;
    m[6*DW +: DW] = 8'hFF; m[7*DW +: DW] = 8'hFE;
    m[2*DW +: DW] = 8'h80; m[3*DW +: DW] = 8'h80;
    m[8*DW +: DW] = 8'h80; m[9*DW +: DW] = 8'h7F;
`ifdef POOL_RELU_EN
    exp_avg = 8'h00; exp_max = 8'h00;
`else
    exp_avg = 8'hFE; exp_max = 8'hFF;
`endif
    test_stream("signed_avg", m, 1'b1, 1'b0);
    tests_run++;
    if (obs_data[0] !== exp_avg) begin
      tests_failed++;
      $display("[TB] FAIL signed_avg_w0: got %h required %h", obs_data[0], exp_avg);
    end
    test_stream("signed_max", m, 1'b0, 1'b0);
    tests_run++;
    if (obs_data[0] !== exp_max) begin
      tests_failed++;
      $display("[TB] FAIL signed_max_w0: got %h required %h", obs_data[0], exp_max);
    end
    tests_run++;
    if (obs_data[1] !== 8'h7F) begin
      tests_failed++;
      $display("[TB] FAIL signed_max_w1: got %h required 7f", obs_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_map(random_map(), 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_row !== e.row || out_col !== e.col) begin
        tests_failed++;
        $display("[TB] FAIL midrst_pre: got v=%b %h (%0d,%0d) required v=1 %h (%0d,%0d)",
                 out_valid, out_data, out_row, out_col, e.data, e.row, e.col);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_row !== 2'd0 || out_col !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs: valid/busy %b/%b data %h (%0d,%0d) required 0/0 00 (0,0)",
               out_valid, busy, out_data, out_row, out_col);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    test_stream("midrst_restart", random_map(), 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [MAPW-1:0] map_a, map_b;
    exp_t            e;
    map_a = random_map();
    map_b = random_map();
    apply_map(map_a, 1'b0);
    fmap_lin  = map_b;
    mode      = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < NWIN; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_last !== e.last) begin
        tests_failed++;
        $display("[TB] FAIL b2b_map_a[%0d]: got v=%b rdy=%b %h last=%b required v=1 rdy=0 %h last=%b",
                 k, out_valid, in_ready, out_data, out_last, e.data, e.last);
      end
    end
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_gap: in_ready/valid %b/%b required 1/0", in_ready, out_valid);
    end
    push_map(map_b, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_accept: busy/in_ready/valid %b/%b/%b required 1/0/0", busy, in_ready, out_valid);
    end
    for (int k = 0; k < NWIN; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_row !== e.row || out_col !== e.col || out_last !== e.last) begin
        tests_failed++;
        $display("[TB] FAIL b2b_map_b[%0d]: got v=%b %h (%0d,%0d) last=%b required v=1 %h (%0d,%0d) last=%b",
                 k, out_valid, out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
      end
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_end: valid/in_ready %b/%b required 0/1", out_valid, in_ready);
    end
  endtask

  // Test sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int e = 0; e < IH*IW; e++) idx_map[e*DW +: DW] = DW'(e);
    test_reset();
    test_max_mode();
    test_avg_mode();
    test_backpressure();
    test_signed();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pool_window_walker.md
Name: pool_window_walker

Overview:
Parametrised 2-D pooling engine. It captures one flattened single-channel feature map and walks every KxK pooling window at stride S in raster order. Each window is reduced by max or average and streamed out over a valid/ready handshake. It sits between the conv output buffer and the pooled-map writer, replacing fixed window muxing with internal counters and backpressure.

Parameters:
DW, 8, element width; elements are two's-complement signed.
IH, 6, input map height.
IW, 6, input map width.
K, 2, window size (KxK); must be a power of 2 (elaboration-time check).
S, 2, stride; requires (IH-K)%S==0 and (IW-K)%S==0 (elaboration-time check).
Derived: OH=(IH-K)/S+1, OW=(IW-K)/S+1, RW=clog2(OH), CW=clog2(OW) (min 1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  feature map offered.
in_ready  out  1  engine can accept a map.
fmap_lin  in  IH*IW*DW  element (y,x) at bits [(y*IW+x)*DW +: DW].
mode  in  1  0 = max, 1 = average; sampled at map accept.
out_valid  out  1  out_data holds a pooled result.
out_ready  in  1  consumer accepts the result.
out_data  out  DW  pooled value.
out_row  out  RW  window row index of out_data.
out_col  out  CW  window column index of out_data.
out_last  out  1  out_data is window (OH-1, OW-1).
busy  out  1  high in RUN state.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid, out_data, out_row, out_col, out_last, busy = 0.
  - Internal map register and counters = 0.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register fmap_lin and mode, clear r/c counters, go to RUN.
- FSM RUN:
  - in_ready = 0; in_valid is ignored.
  - The output register loads window (r,c) the cycle after the counters point to it.
  - First out_valid = 1 on cycle T+1, where T is the accept edge.
- Output handshake:
  - The transfer occurs on out_valid && out_ready.
  - On a transfer, counters advance: c+1, wrapping to 0 with r+1.
  - The next result is presented the following cycle (full throughput, one result/cycle with out_ready held high).
  - While out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable.
- End of map:
  - A transfer with out_last = 1 returns the FSM to IDLE.
  - out_valid = 0 and in_ready = 1 on the next cycle. No overlap of maps.
- Window addressing: window (r,c) covers elements (r*S+i, c*S+j) for i,j in 0..K-1.
- Max mode: signed maximum of the K*K elements.
- Average mode:
  - Signed sum in DW+clog2(K*K) bits; no overflow is possible.
  - Result is the sum arithmetically right-shifted by clog2(K*K), i.e. floor toward -inf.
  - The result always fits in DW.
- Reset mid-operation: all outputs return to reset values immediately; the partially walked map is discarded.

Optional Feature:
POOL_RELU_EN.
- Defined: after reduction, a negative result is clamped to 0 before the output register. Applies to both modes.
- Undefined: the signed result passes through unchanged.
- Handshake and latency are identical in both builds.

Decomposition:
- Package pool_pkg:
  - POOL_MAX / POOL_AVG mode constants.
  - State encoding constants for IDLE/RUN.
  - clog2 helper function.
  - Parameter-legality check macro or function.
- Sub-module pool_win_reduce (combinational):
  - Inputs: K*K flattened elements and mode.
  - Output: reduced DW value; includes the POOL_RELU_EN clamp.
- Top module holds the FSM, counters, map register, window gather and output register.

Test Plan:
1. IH=IW=6, K=S=2, map element = index 0..35, mode = 0, out_ready = 1.
   - Required out_data: 7,9,11,19,21,23,31,33,35 on consecutive cycles.
   - out_last high only on 35; in_ready returns 1 the cycle after.
2. Same map, mode = 1.
   - Required out_data: 3,5,7,15,17,19,27,29,31.
   - out_row/out_col step (0,0)..(2,2).
3. Backpressure: drop out_ready for 3 cycles while window (1,1) is presented.
   - out_data = 21 (max mode), out_row = 1, out_col = 1 held stable.
   - Resumes with 23 after the handshake.
4. Signed data, window {-1,-1,-1,-2}.
   - Avg mode gives -2 (0xFE); max mode gives -1 (0xFF).
   - With POOL_RELU_EN, both give 0.
   - Window {-128,-128,-128,127}, max mode: 127.
5. Assert rst_n low after the 4th transfer.
   - out_valid = 0 immediately; in_ready = 1 after release.
   - A new map restarts at (0,0).
6. Hold in_valid high with a different map during RUN.
   - It is ignored; it is accepted exactly one cycle after the out_last transfer.
   - Its first result appears the cycle after that accept.
